// File: rtl/prog_loader.sv
// Boot-time program loader: receives a framed byte stream (length, payload,
// XOR checksum), writes the payload into program memory from address 0, and
// holds the processor in reset until a frame checks out, then releases it
// after RST_HOLD cycles.
module prog_loader #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int RST_HOLD = 4
) (
    input  logic              clk,
    input  logic              rstn_ext,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              rstn_inter,
    output logic              load_done,
    output logic              load_err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] DEPTH_D = DATA_W'(DEPTH);
    localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    // count is one bit wider than the address so a full-depth frame
    // reaches DEPTH without wrapping before the last write
    logic [CNT_W-1:0]  len_r, len_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [DATA_W-1:0] csum_r, csum_nxt_s;
    logic [7:0]        hold_r, hold_nxt_s;

    logic              in_ready_r, in_ready_nxt_s;
    logic              mem_we_r, mem_we_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nxt_s;
    logic              rstn_inter_r, rstn_inter_nxt_s;
    logic              load_done_r, load_done_nxt_s;
    logic              load_err_r, load_err_nxt_s;

    logic xfer_s;
    logic len_ok_s;
    logic last_s;
    logic csum_ok_s;

    assign xfer_s    = in_valid && in_ready_r;
    assign len_ok_s  = (in_data != {DATA_W{1'b0}}) && (in_data <= DEPTH_D);
    assign last_s    = ((cnt_r + {{(CNT_W-1){1'b0}}, 1'b1}) == len_r);
    assign csum_ok_s = (in_data == csum_r);

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn_ext) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    state_nxt_s = len_ok_s ? ST_LOAD : ST_ERROR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (xfer_s && last_s) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_CHECK: begin
                if (xfer_s) begin
                    state_nxt_s = csum_ok_s ? ST_HOLD : ST_ERROR;
                end else begin
                    state_nxt_s = ST_CHECK;
                end
            end
            ST_HOLD: begin
                // last decrement to zero coincides with entering RUN
                if (hold_r <= 8'd1) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_RUN:   state_nxt_s = ST_RUN;
            ST_ERROR: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        len_nxt_s       = len_r;
        cnt_nxt_s       = cnt_r;
        csum_nxt_s      = csum_r;
        hold_nxt_s      = hold_r;
        mem_we_nxt_s    = 1'b0;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        load_err_nxt_s  = load_err_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s && len_ok_s) begin
                    len_nxt_s  = in_data[CNT_W-1:0];
                    cnt_nxt_s  = {CNT_W{1'b0}};
                    csum_nxt_s = {DATA_W{1'b0}};
                end else if (xfer_s) begin
                    load_err_nxt_s = 1'b1;
                end else begin
                    len_nxt_s = len_r;
                end
            end
            ST_LOAD: begin
                if (xfer_s) begin
                    csum_nxt_s      = csum_r ^ in_data;
                    mem_we_nxt_s    = 1'b1;
                    mem_addr_nxt_s  = cnt_r[ADDR_W-1:0];
                    mem_wdata_nxt_s = in_data;
                    cnt_nxt_s       = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_CHECK: begin
                if (xfer_s && csum_ok_s) begin
                    load_err_nxt_s = 1'b0;
                    hold_nxt_s     = HOLD_INIT;
                end else if (xfer_s) begin
                    load_err_nxt_s = 1'b1;
                end else begin
                    hold_nxt_s = hold_r;
                end
            end
            ST_HOLD: begin
                hold_nxt_s = hold_r - 8'd1;
            end
            default: begin
                hold_nxt_s = hold_r;
            end
        endcase
        in_ready_nxt_s   = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_LOAD) ||
                           (state_nxt_s == ST_CHECK);
        rstn_inter_nxt_s = (state_nxt_s == ST_RUN);
        load_done_nxt_s  = (state_nxt_s == ST_RUN);
    end

    // Datapath and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn_ext) begin
            len_r        <= {CNT_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            csum_r       <= {DATA_W{1'b0}};
            hold_r       <= 8'd0;
            in_ready_r   <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            rstn_inter_r <= 1'b0;
            load_done_r  <= 1'b0;
            load_err_r   <= 1'b0;
        end else begin
            len_r        <= len_nxt_s;
            cnt_r        <= cnt_nxt_s;
            csum_r       <= csum_nxt_s;
            hold_r       <= hold_nxt_s;
            in_ready_r   <= in_ready_nxt_s;
            mem_we_r     <= mem_we_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
            rstn_inter_r <= rstn_inter_nxt_s;
            load_done_r  <= load_done_nxt_s;
            load_err_r   <= load_err_nxt_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign rstn_inter = rstn_inter_r;
    assign load_done  = load_done_r;
    assign load_err   = load_err_r;

endmodule
